// File: rtl/alu_pipe_hs.sv
// Pipelined ALU with valid/ready handshake, per-stage backpressure and flush.
// Stage 0 registers the ALU result and flags; later stages only carry them toward writeback.

module alu_pipe_hs_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          load,
  input  logic          vin,
  input  logic [DW-1:0] din,
  output logic          vq,
  output logic [DW-1:0] dq
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vq <= 1'b0;
      dq <= '0;
    end else begin
      if (flush)     vq <= 1'b0;
      else if (load) vq <= vin;
      // Data moves only with a valid entry, so stalled or idle outputs stay put.
      if (load && vin) dq <= din;
    end
  end
endmodule

module alu_pipe_hs #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 3,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             illegal
);
  localparam int DW = WIDTH + 5;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_SLT  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,  OP_NOR  = 5'd9,  OP_SGE  = 5'd10, OP_SLTU = 5'd11,
    OP_SGEU = 5'd12
  } op_e;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] res;
  logic [SHW-1:0]   shamt;
  logic             c, ov, ill, slt, sltu, sa;

  assign shamt = operand_b[SHW-1:0];
  assign sa    = operand_a[WIDTH-1];
  assign slt   = $signed(operand_a) < $signed(operand_b);
  assign sltu  = operand_a < operand_b;

  always_comb begin
    sum = {1'b0, operand_a} + {1'b0, operand_b};
    dif = {1'b0, operand_a} + {1'b0, ~operand_b} + {{WIDTH{1'b0}}, 1'b1};
    res = '0;
    c   = 1'b0;
    ov  = 1'b0;
    ill = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        ov  = (sa == operand_b[WIDTH-1]) && (sum[WIDTH-1] != sa);
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        c   = dif[WIDTH];
        ov  = (sa != operand_b[WIDTH-1]) && (dif[WIDTH-1] != sa);
      end
      OP_AND:  res = operand_a & operand_b;
      OP_OR:   res = operand_a | operand_b;
      OP_XOR:  res = operand_a ^ operand_b;
      OP_NOR:  res = ~(operand_a | operand_b);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
      OP_SGE:  res = {{(WIDTH-1){1'b0}}, ~slt};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, sltu};
      OP_SGEU: res = {{(WIDTH-1){1'b0}}, ~sltu};
      OP_SLL:  res = operand_a << shamt;
      OP_SRL:  res = operand_a >> shamt;
      OP_SRA:  res = $signed(operand_a) >>> shamt;
      default: ill = 1'b1;
    endcase
  end

  logic [DW-1:0] din;
  assign din = {ill, res[WIDTH-1], ov, c, (res == '0), res};

  logic [STAGES-1:0]         vld_pipe, load, sin_v;
  logic [STAGES-1:0][DW-1:0] dat_pipe, sin_d;
  logic                      accept;

  // Ready ripples back from the output; an empty stage always loads so bubbles collapse.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    load = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = !vld_pipe[i] || nxt;
      nxt     = load[i];
    end
  end

  assign in_ready = load[0] && !flush && !reset;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign sin_v[i] = accept;
      assign sin_d[i] = din;
    end else begin : g_body
      assign sin_v[i] = vld_pipe[i-1];
      assign sin_d[i] = dat_pipe[i-1];
    end
    alu_pipe_hs_stage #(.DW(DW)) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (load[i]),
      .vin   (sin_v[i]),
      .din   (sin_d[i]),
      .vq    (vld_pipe[i]),
      .dq    (dat_pipe[i])
    );
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign {illegal, negative, overflow, carry, zero, result} = dat_pipe[STAGES-1];

endmodule

// File: doc/alu_pipe_hs.md
# alu_pipe_hs

Parametrised pipelined ALU for the RISC-V datapath, successor to the fixed 32-bit three-stage ALU. It adds configurable operand width and pipeline depth, a valid/ready handshake with per-stage backpressure, a synchronous flush, unsigned compare operations, and registered carry, overflow, negative and illegal-op flags that travel with each result. It sits between the issue/operand-read logic and writeback.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- STAGES, 3, pipeline register stages from input to output; legal range 1..8.
- SHW, $clog2(WIDTH), derived parameter (not overridable); shift-amount width.
- clk  input  1  clock; all registers on rising edge.
- reset  input  1  asynchronous, active-high; clears every pipeline register.
- flush  input  1  synchronous; when high, all in-flight entries are discarded on this edge.
- in_valid  input  1  operand_a, operand_b and alu_op are valid.
- in_ready  output  1  pipeline accepts the input on this edge.
- operand_a  input  WIDTH  first operand.
- operand_b  input  WIDTH  second operand.
- alu_op  input  5  operation code.
- out_valid  output  1  output entry is valid.
- out_ready  input  1  consumer takes the output entry on this edge.
- result  output  WIDTH  result of the output entry.
- zero  output  1  result == 0.
- carry  output  1  ADD: carry out of bit WIDTH-1. SUB: 1 when there is no borrow (a >= b unsigned). All other ops: 0.
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- negative  output  1  result[WIDTH-1].
- illegal  output  1  alu_op is not in the opcode map below.

## Operation
- Opcodes:
  - 00000 ADD.
  - 00001 SUB.
  - 00010 AND.
  - 00011 OR.
  - 00100 XOR.
  - 00101 SLT (signed).
  - 00110 SLL.
  - 00111 SRL.
  - 01000 SRA.
  - 01001 NOR.
  - 01010 SGE (signed).
  - 01011 SLTU.
  - 01100 SGEU.
  - Any other code: result 0, all arithmetic flags 0, illegal=1.
- Compare ops return 1 or 0, zero-extended to WIDTH.
- Shifts use operand_b[SHW-1:0] only; upper bits are ignored.
- ADD/SUB are computed in WIDTH+1 bits.
  - carry = bit WIDTH of a + b for ADD, or of a + ~b + 1 for SUB.
  - overflow = operands' signs agree (ADD) or differ (SUB), and the result sign differs from operand_a's sign.
- Datapath:
  - All computation is combinational on the input side.
  - Result and all flags (zero included) are registered into stage 0.
  - Stages 1..STAGES-1 are pure pass-through registers.
  - The output ports are driven directly by stage STAGES-1.
- Handshake, per stage i, each holding a valid bit:
  - load[STAGES-1] = !valid[STAGES-1] || out_ready.
  - load[i] = !valid[i] || load[i+1].
  - in_ready = load[0] && !flush && !reset.
- Transfer rules:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - A stage whose load is high captures the previous stage's valid and data; stage 0 captures the input handshake.
  - Bubbles collapse: an empty stage loads even when downstream is stalled.
- While out_valid=1 and out_ready=0, every output port holds stable.
- Flush:
  - All valid bits are cleared on the edge; data registers may keep stale values.
  - flush together with in_valid: the input is not accepted (in_ready=0).
  - flush together with out_ready while out_valid=1: the output entry still counts as consumed on that edge.
- Reset, mid-operation included: all valid bits and data/flag registers clear immediately to 0; no partial entries survive.

## Timing
- Reset values:
  - out_valid=0, result=0, carry=0, overflow=0, negative=0, illegal=0.
  - zero=0 (the register is cleared, not recomputed).
  - in_ready=0 while reset is high; 1 on the first cycle after release.
- Latency with out_ready held high: an input accepted at edge N appears with out_valid=1 after edge N+STAGES-1. STAGES=1 gives one register of latency.
- Throughput: one operation per cycle when out_ready=1. in_ready depends combinationally on out_ready (ready path is not registered).
- Capacity: STAGES entries. With out_ready=0 and the pipeline full, in_ready=0.
- Ordering: strictly in order; no reordering or dropping except by flush.

## Test plan
- Reset mid-stream:
  - Stimulus: WIDTH=32, STAGES=3; fill 3 ADDs; assert reset for 1 cycle.
  - Required response: out_valid=0, all outputs 0, and none of the 3 results emerge after release.
- Arithmetic flags:
  - Stimulus: WIDTH=32, out_ready=1; ADD 0x7FFFFFFF+1, then ADD 0xFFFFFFFF+1, then SUB 3-5.
  - Required response (one per cycle, starting 3 edges after the first input):
    - 0x80000000, overflow=1, carry=0, negative=1.
    - 0x00000000, zero=1, carry=1, overflow=0.
    - 0xFFFFFFFE, carry=0, negative=1.
- Parametrisation:
  - Stimulus: WIDTH=16, STAGES=1; SRA 0x8000 by operand_b=0x0013, then SLTU 0x0001 vs 0xFFFF.
  - Required response: 0xF000 (shift by 3; upper bits of operand_b ignored), then 0x0001, each one edge after acceptance.
- Backpressure:
  - Stimulus: STAGES=3; out_ready=0; drive 5 consecutive valid inputs.
  - Required response: exactly 3 accepted and in_ready=0 afterwards.
  - Then: toggle out_ready 1/0 per cycle. Required response: the 3 results emerge in order, and outputs stay stable while stalled.
- Flush collision:
  - Stimulus: pipeline holds 2 entries; assert flush with in_valid=1 and out_ready=1.
  - Required response: in_ready=0 on that cycle, the head entry is counted as consumed, and out_valid=0 on the next cycle.
- Illegal op:
  - Stimulus: alu_op=11111, a=5, b=7.
  - Required response: result=0, illegal=1, zero=1, carry=0, overflow=0.
